// File: rtl/adaptive_traffic_light_controller_pkg.sv
// Shared state codes, light codes and approach indices for the four-approach
// traffic light controller, plus the round-robin and state-code helpers.
package adaptive_traffic_light_controller_pkg;

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_NS_G = 4'd1;
  localparam logic [3:0] ST_NS_Y = 4'd2;
  localparam logic [3:0] ST_SN_G = 4'd3;
  localparam logic [3:0] ST_SN_Y = 4'd4;
  localparam logic [3:0] ST_EW_G = 4'd5;
  localparam logic [3:0] ST_EW_Y = 4'd6;
  localparam logic [3:0] ST_WE_G = 4'd7;
  localparam logic [3:0] ST_WE_Y = 4'd8;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;

  localparam logic [1:0] APP_NS = 2'd0;
  localparam logic [1:0] APP_SN = 2'd1;
  localparam logic [1:0] APP_EW = 2'd2;
  localparam logic [1:0] APP_WE = 2'd3;

  // First requester at or after start, wrapping; only meaningful when req != 0.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [3:0] green_code(input logic [1:0] app);
    return {1'b0, app, 1'b1};
  endfunction

  function automatic logic [3:0] yellow_code(input logic [1:0] app);
    return {1'b0, app, 1'b0} + 4'd2;
  endfunction

endpackage

// File: rtl/adaptive_traffic_light_controller_phase_timer.sv
// Phase timer: counts cycles spent in the current state, clears on a state
// change, saturates at all-ones and flags when the current limit is reached.
module adaptive_traffic_light_controller_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic [W-1:0] limit_i,
  output logic         done_o
);

  logic [W-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (count_q != '1) begin
      count_q <= count_q + W'(1);
    end
  end

  // count+1 >= limit is limit-1 <= count without underflow when limit is small.
  assign done_o = ({1'b0, count_q} + (W+1)'(1)) >= {1'b0, limit_i};

endmodule

// File: rtl/adaptive_traffic_light_controller.sv
// Four-approach Moore traffic light controller: round-robin service, one green
// at a time, congestion-extended green, fixed yellow.
module adaptive_traffic_light_controller
  import adaptive_traffic_light_controller_pkg::*;
#(
  parameter int GREEN_BASE  = 5,
  parameter int GREEN_EXT   = 10,
  parameter int YELLOW_TIME = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       S1_NS,
  input  logic       S1_SN,
  input  logic       S1_EW,
  input  logic       S1_WE,
  input  logic       S5_NS,
  input  logic       S5_SN,
  input  logic       S5_EW,
  input  logic       S5_WE,
  output logic [3:0] current_state,
  output logic [1:0] NS_light,
  output logic [1:0] SN_light,
  output logic [1:0] EW_light,
  output logic [1:0] WE_light
);

  localparam int TW = ($clog2(GREEN_EXT + 1) > 4) ? $clog2(GREEN_EXT + 1) : 4;

  logic [3:0]    state_q, state_d;
  logic [3:0]    req, cong;
  logic          legal, is_green, is_yellow, timer_done;
  logic [1:0]    app;
  logic [TW-1:0] limit;
  logic [1:0]    lights [4];

  // Indexed by approach number (NS=0 .. WE=3); congestion only counts with cars present.
  assign req  = {S1_WE, S1_EW, S1_SN, S1_NS};
  assign cong = {S5_WE, S5_EW, S5_SN, S5_NS} & req;

  assign legal     = (state_q != ST_IDLE) && (state_q <= ST_WE_Y);
  assign is_green  = legal && state_q[0];
  assign is_yellow = legal && !state_q[0];
  assign app       = 2'((state_q - 4'd1) >> 1);

  always_comb begin
    limit = TW'(YELLOW_TIME);
    if (is_green) limit = cong[app] ? TW'(GREEN_EXT) : TW'(GREEN_BASE);
  end

  adaptive_traffic_light_controller_phase_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .rst_n   (rst),
    .clear_i (state_d != state_q),
    .limit_i (limit),
    .done_o  (timer_done)
  );

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = ST_IDLE;
    if (state_q == ST_IDLE) begin
      if (|req) state_d = green_code(rr_pick(req, APP_NS));
    end else if (is_green) begin
      state_d = (!req[app] || timer_done) ? yellow_code(app) : state_q;
    end else if (is_yellow) begin
      if (!timer_done)  state_d = state_q;
      else if (|req)    state_d = green_code(rr_pick(req, app + 2'd1));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) lights[i] = LIGHT_RED;
    if (is_green)  lights[app] = LIGHT_GREEN;
    if (is_yellow) lights[app] = LIGHT_YELLOW;
  end

  assign current_state = state_q;
  assign NS_light      = lights[APP_NS];
  assign SN_light      = lights[APP_SN];
  assign EW_light      = lights[APP_EW];
  assign WE_light      = lights[APP_WE];

endmodule

// File: tb/tb_adaptive_traffic_light_controller.sv
// Self-checking bench: directed phase sequences with literal expectations plus
// randomized sensor traffic compared every cycle against a behavioural model.
module tb_adaptive_traffic_light_controller;

  localparam int GB = 5;
  localparam int GE = 10;
  localparam int YT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] s1  = 4'd0;  // bit i = approach i: NS, SN, EW, WE
  logic [3:0] s5  = 4'd0;
  logic [3:0] cur;
  logic [1:0] ns_l, sn_l, ew_l, we_l;

  int checks = 0;
  int errors = 0;

  int m_phase = 0;  // 0 idle, 1 green, 2 yellow
  int m_app   = 0;
  int m_age   = 0;  // completed cycles in the current phase
  int inj_cnt = 0;
  int inj_done = 0;

  adaptive_traffic_light_controller #(
    .GREEN_BASE(GB), .GREEN_EXT(GE), .YELLOW_TIME(YT)
  ) dut (
    .clk(clk), .rst(rst),
    .S1_NS(s1[0]), .S1_SN(s1[1]), .S1_EW(s1[2]), .S1_WE(s1[3]),
    .S5_NS(s5[0]), .S5_SN(s5[1]), .S5_EW(s5[2]), .S5_WE(s5[3]),
    .current_state(cur),
    .NS_light(ns_l), .SN_light(sn_l), .EW_light(ew_l), .WE_light(we_l)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_from(input logic [3:0] req, input int start);
    for (int k = 0; k < 4; k++)
      if (req[(start + k) % 4]) return (start + k) % 4;
    return start;
  endfunction

  // Reference model of the intersection from the phase rules.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase <= 0; m_app <= 0; m_age <= 0;
    end else if (inj_cnt != inj_done) begin
      inj_done <= inj_cnt; m_phase <= 0; m_age <= 0;
    end else begin
      case (m_phase)
        0: if (s1 != 0) begin
             m_phase <= 1; m_app <= first_from(s1, 0); m_age <= 0;
           end
        1: begin
             if (!s1[m_app] || (m_age + 1 >= ((s1[m_app] && s5[m_app]) ? GE : GB))) begin
               m_phase <= 2; m_age <= 0;
             end else m_age <= m_age + 1;
           end
        default: begin
             if (m_age + 1 >= YT) begin
               m_age <= 0;
               if (s1 == 0) m_phase <= 0;
               else begin
                 m_phase <= 1; m_app <= first_from(s1, (m_app + 1) % 4);
               end
             end else m_age <= m_age + 1;
           end
      endcase
    end
  end

  function automatic int exp_light(input int i);
    if (m_phase == 0 || m_app != i) return 0;
    return (m_phase == 1) ? 2 : 1;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      check("model_state", cur, (m_phase == 0) ? 0 : (m_phase == 1 ? 1 + 2*m_app : 2 + 2*m_app));
      check("model_NS_light", ns_l, exp_light(0));
      check("model_SN_light", sn_l, exp_light(1));
      check("model_EW_light", ew_l, exp_light(2));
      check("model_WE_light", we_l, exp_light(3));
    end
  end

  // Checks the state for len consecutive cycles, ending on the next phase's first negedge.
  task automatic expect_phase(input int code, input int len);
    for (int i = 0; i < len; i++) begin
      check("phase_state", cur, code);
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_state", cur, 0);
    check("reset_lights", {ns_l, sn_l, ew_l, we_l}, 0);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_hold", cur, 0);
    end

    // NS alone, no congestion
    s1[0] = 1'b1;
    @(negedge clk);
    check("ns_green_light", ns_l, 2);
    expect_phase(1, 5);
    check("ns_yellow_light", ns_l, 1);
    expect_phase(2, 2);
    expect_phase(1, 5);
    expect_phase(2, 2);

    // NS congested: extended green, then congestion dropped at timer 7
    s5[0] = 1'b1;
    expect_phase(1, 10);
    expect_phase(2, 2);
    expect_phase(1, 7);
    check("drop_s5_t7", cur, 1);
    s5[0] = 1'b0;
    @(negedge clk);
    expect_phase(2, 1);
    s1[1] = 1'b1;
    expect_phase(2, 1);
    expect_phase(3, 5);
    expect_phase(4, 2);
    expect_phase(1, 5);
    expect_phase(2, 1);
    s1[2] = 1'b1; s1[3] = 1'b1; s5[2] = 1'b1;
    expect_phase(2, 1);
    expect_phase(3, 5);
    expect_phase(4, 2);
    expect_phase(5, 10);
    expect_phase(6, 2);
    expect_phase(7, 2);
    s1[3] = 1'b0;
    expect_phase(7, 1);
    expect_phase(8, 2);
    expect_phase(1, 5);
    expect_phase(2, 1);
    s1 = 4'd0; s5 = 4'd0;
    expect_phase(2, 1);
    expect_phase(0, 3);
    check("all_red_after_withdraw", {ns_l, sn_l, ew_l, we_l}, 0);

    // WE alone from idle
    s1[3] = 1'b1;
    expect_phase(0, 1);
    expect_phase(7, 5);
    expect_phase(8, 2);
    expect_phase(7, 5);
    expect_phase(8, 2);

    // Reset in the middle of EW green
    s1 = 4'b0100;
    expect_phase(7, 1);
    expect_phase(8, 2);
    expect_phase(5, 3);
    #2 rst = 1'b0;
    #1;
    check("async_reset_state", cur, 0);
    check("async_reset_lights", {ns_l, sn_l, ew_l, we_l}, 0);
    @(negedge clk);
    rst = 1'b1;
    s1 = 4'd0;
    repeat (3) @(negedge clk);

    // Illegal state code recovers to idle
    #2;
    force dut.state_q = 4'd11;
    inj_cnt++;
    #1;
    release dut.state_q;
    check("illegal_state_seen", cur, 11);
    check("illegal_lights_red", {ns_l, sn_l, ew_l, we_l}, 0);
    @(negedge clk);
    check("illegal_to_idle", cur, 0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) s1 = 4'($urandom);
      if ($urandom_range(0, 5) == 0) s5 = 4'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
